// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM encoding and counter width.
// Also intended for the LED stage and testbenches that decode debouncer state.
package btn_debounce_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/btn_debounce_if.sv
// Button-side signal bundle: raw active-low button in, debounced level and event strobes out.
interface btn_debounce_if;

  logic btn_n;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output btn_n,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  btn_n,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );

endinterface

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; resets to 1 so an active-low
// button reads as released while in reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic ff1_reg;
  logic ff2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_reg <= 1'b1;
      ff2_reg <= 1'b1;
    end else begin
      ff1_reg <= d;
      ff2_reg <= ff1_reg;
    end
  end

  assign q = ff2_reg;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizes btn_n, accepts a level only after it has been
// stable for DEBOUNCE_CYCLES, and emits press/release/long-press strobes.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int LONG_CYCLES     = 27_000_000
) (
  input logic            sys_clk,
  input logic            sys_reset,
  btn_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic btn_sync_n;
  logic raw;

  sync_2ff u_sync (
    .clk   (sys_clk),
    .rst_n (sys_reset),
    .d     (bus.btn_n),
    .q     (btn_sync_n)
  );

  assign raw = ~btn_sync_n;

  db_state_t        state_reg, state_next;
  logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             long_reg, long_next;
  logic             long_done_reg, long_done_next;
  logic             long_fire;

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_reg     <= IDLE;
      db_cnt_reg    <= '0;
      hold_cnt_reg  <= '0;
      level_reg     <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      long_reg      <= 1'b0;
      long_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      db_cnt_reg    <= db_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      level_reg     <= level_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
      long_reg      <= long_next;
      long_done_reg <= long_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    db_cnt_next  = db_cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (raw) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!raw) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = PRESSED;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (!raw) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        // A rebound back to pressed keeps the level and hold count untouched.
        if (raw) begin
          state_next = PRESSED;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next   = IDLE;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // level_reg gates the long event so the stale saturated hold count seen on the
  // edge after a release cannot re-fire it once long_done has been cleared.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (!level_reg) begin
      hold_cnt_next = '0;
    end else if (hold_cnt_reg != LONG_LAST) begin
      hold_cnt_next = hold_cnt_reg + 1'b1;
    end
    long_fire      = level_reg && (hold_cnt_reg == LONG_LAST) && !long_done_reg;
    long_next      = long_fire;
    long_done_next = long_done_reg;
    if (release_next) begin
      long_done_next = 1'b0;
    end else if (long_fire) begin
      long_done_next = 1'b1;
    end
  end

  assign bus.btn_level     = level_reg;
  assign bus.press_pulse   = press_reg;
  assign bus.release_pulse = release_reg;
  assign bus.long_pulse    = long_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20: table of
// press waveforms with expected strobe edges, plus hand-written reset sequences.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  btn_debounce_if bif();

  btn_debounce #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20)
  ) dut (
    .sys_clk   (clk),
    .sys_reset (rst_n),
    .bus       (bif)
  );

  always #5 clk = ~clk;

  // pressed bit k = button held down for the edge numbered k; -1 = event not expected
  typedef struct {
    logic [63:0] pressed;
    int          n_edges;
    int          press_edge;
    int          release_edge;
    int          long_edge;
  } vec_t;

  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;

  int press_cnt, release_cnt, long_cnt;
  int press_first, release_first, long_first;
  int level_rise, level_fall;

  function automatic logic [63:0] span(input int a, input int b);
    logic [63:0] m;
    m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    press_cnt = 0; release_cnt = 0; long_cnt = 0;
    press_first = -1; release_first = -1; long_first = -1;
    level_rise = -1; level_fall = -1;
  endtask

  task automatic observe(input int k);
    if (bif.press_pulse) begin
      press_cnt++;
      if (press_first < 0) press_first = k;
    end
    if (bif.release_pulse) begin
      release_cnt++;
      if (release_first < 0) release_first = k;
    end
    if (bif.long_pulse) begin
      long_cnt++;
      if (long_first < 0) long_first = k;
    end
    if (bif.btn_level && level_rise < 0) level_rise = k;
    if (!bif.btn_level && level_rise >= 0 && level_fall < 0) level_fall = k;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    bif.btn_n = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{span(1, 10),               25,  7, 17, -1};
    vecs[1] = '{span(1, 1) | span(3, 20),  20,  9, -1, -1};
    vecs[2] = '{span(1, 30),               40,  7, 37, 27};
    vecs[3] = '{span(1, 14) | span(16, 17), 30, 7, 24, -1};
    vecs[4] = '{span(1, 19),               32,  7, 26, -1};
    vecs[5] = '{span(1, 4),                15, -1, -1, -1};
    vecs[6] = '{span(1, 5),                20,  7, 12, -1};

    // Reset state, including a pressed button while reset is held
    bif.btn_n = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level",   int'(bif.btn_level),     0);
    check("rst_press",   int'(bif.press_pulse),   0);
    check("rst_release", int'(bif.release_pulse), 0);
    check("rst_long",    int'(bif.long_pulse),    0);

    for (int v = 0; v < 7; v++) begin
      reset_dut();
      clear_obs();
      for (int k = 1; k <= vecs[v].n_edges; k++) begin
        @(negedge clk);
        bif.btn_n = ~vecs[v].pressed[k];
        @(posedge clk);
        #1;
        observe(k);
      end
      $display("[TB] vec %0d: press@%0d release@%0d long@%0d level_rise@%0d level_fall@%0d",
               v, press_first, release_first, long_first, level_rise, level_fall);
      check($sformatf("v%0d_press_cnt", v),   press_cnt,     (vecs[v].press_edge >= 0) ? 1 : 0);
      check($sformatf("v%0d_press_edge", v),  press_first,   vecs[v].press_edge);
      check($sformatf("v%0d_rel_cnt", v),     release_cnt,   (vecs[v].release_edge >= 0) ? 1 : 0);
      check($sformatf("v%0d_rel_edge", v),    release_first, vecs[v].release_edge);
      check($sformatf("v%0d_long_cnt", v),    long_cnt,      (vecs[v].long_edge >= 0) ? 1 : 0);
      check($sformatf("v%0d_long_edge", v),   long_first,    vecs[v].long_edge);
      check($sformatf("v%0d_level_rise", v),  level_rise,    vecs[v].press_edge);
      check($sformatf("v%0d_level_fall", v),  level_fall,    vecs[v].release_edge);
    end

    // Reset during debounce: asserted before edge 5, released before edge 8, held throughout
    reset_dut();
    clear_obs();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bif.btn_n = 1'b0;
      if (k == 5) rst_n = 1'b0;
      if (k == 8) rst_n = 1'b1;
      @(posedge clk);
      #1;
      observe(k);
    end
    $display("[TB] reset mid-debounce: press@%0d count %0d release count %0d",
             press_first, press_cnt, release_cnt);
    check("rstdb_press_cnt",  press_cnt,   1);
    check("rstdb_press_edge", press_first, 14);
    check("rstdb_level_rise", level_rise,  14);
    check("rstdb_rel_cnt",    release_cnt, 0);
    check("rstdb_long_cnt",   long_cnt,    0);

    // Reset during hold: level must drop at once with no release strobe now or later
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rsthold_level", int'(bif.btn_level), 0);
    clear_obs();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bif.btn_n = 1'b1;
      if (k == 4) rst_n = 1'b1;
      @(posedge clk);
      #1;
      observe(k);
    end
    $display("[TB] reset mid-hold: press %0d release %0d long %0d",
             press_cnt, release_cnt, long_cnt);
    check("rsthold_press_cnt", press_cnt,   0);
    check("rsthold_rel_cnt",   release_cnt, 0);
    check("rsthold_long_cnt",  long_cnt,    0);
    check("rsthold_level_end", int'(bif.btn_level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
